// File: rtl/aes_block_serializer_if.sv
// rtl/aes_block_serializer_if.sv - word stream interface carrying serialized AES output
//
// Stream bundle: data, byte strobes, valid and ready.
// Modport source drives data/strb/valid and samples ready; sink is the reverse.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/aes_block_serializer.sv
// rtl/aes_block_serializer.sv - two-block buffer streaming 128-bit AES results as 32-bit words
//
// Ports:
//   clk_i, rst_ni         clock, synchronous active-low reset
//   test_mode_i           test mode (no functional effect)
//   clear_i               synchronous soft clear, drops buffered blocks and counters
//   block_i/block_valid_i/block_ready_o  block input handshake
//   aes_output            word stream source (word 0 = block bits [DATA_WIDTH-1:0])
//   busy_o                at least one block buffered
//   block_done_o          one-cycle pulse after a block's last word is accepted
//   words_sent_o          words accepted downstream since reset/clear (wraps)
// Build option: AES_SERIALIZER_BSWAP_EN byte-reverses every output word.
module aes_block_serializer #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BLOCK_WIDTH = 128,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   test_mode_i,
  input  logic                   clear_i,
  input  logic [BLOCK_WIDTH-1:0] block_i,
  input  logic                   block_valid_i,
  output logic                   block_ready_o,
  hwpe_stream_intf_stream.source aes_output,
  output logic                   busy_o,
  output logic                   block_done_o,
  output logic [CNT_WIDTH-1:0]   words_sent_o
);

  localparam int unsigned NW    = BLOCK_WIDTH / DATA_WIDTH;
  localparam int unsigned IDX_W = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);

  logic [BLOCK_WIDTH-1:0] head_q, tail_q;
  logic [1:0]             cnt_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   done_q;
  logic [CNT_WIDTH-1:0]   words_q;

  logic                   out_valid;
  logic                   push, pop, pop_last;
  logic [DATA_WIDTH-1:0]  head_words [NW];
  logic [DATA_WIDTH-1:0]  word_sel;
  logic [DATA_WIDTH-1:0]  word_out;

  logic unused_test_mode;
  assign unused_test_mode = test_mode_i;

  // Ready depends on stored state only, so no combinational path from the stream ready.
  assign block_ready_o = (cnt_q != 2'd2);
  assign out_valid     = (cnt_q != 2'd0);
  assign push          = block_valid_i && block_ready_o;
  assign pop           = out_valid && aes_output.ready;
  assign pop_last      = pop && (idx_q == LAST_IDX);

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= 2'd0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      words_q <= '0;
    end else begin
      done_q <= pop_last;
      if (pop) begin
        words_q <= words_q + CNT_WIDTH'(1);
        idx_q   <= pop_last ? '0 : idx_q + IDX_W'(1);
      end

      if (push && !pop_last) begin
        cnt_q <= cnt_q + 2'd1;
      end else if (!push && pop_last) begin
        cnt_q <= cnt_q - 2'd1;
      end

      // On head release the tail moves up; with one block buffered, a coincident
      // push lands directly in the head so the next word follows with no bubble.
      if (pop_last) begin
        if (cnt_q == 2'd2) begin
          head_q <= tail_q;
        end else if (push) begin
          head_q <= block_i;
        end
      end else if (push) begin
        if (cnt_q == 2'd0) begin
          head_q <= block_i;
        end else begin
          tail_q <= block_i;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NW; i++) begin
      head_words[i] = head_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign word_sel = head_words[idx_q];

`ifdef AES_SERIALIZER_BSWAP_EN
  always_comb begin
    word_out = '0;
    for (int b = 0; b < NB; b++) begin
      word_out[b*8 +: 8] = word_sel[(NB-1-b)*8 +: 8];
    end
  end
`else
  assign word_out = word_sel;
`endif

  assign aes_output.valid = out_valid;
  assign aes_output.data  = word_out;
  assign aes_output.strb  = {NB{1'b1}};

  assign busy_o       = out_valid;
  assign block_done_o = done_q;
  assign words_sent_o = words_q;

endmodule
